// File: rtl/crc32_frame_ctrl.sv
// Frame controller for an external byte-wide CRC-32 engine: forwards data bytes
// cut-through, waits for the engine result, then appends the four CRC bytes.
module crc32_frame_ctrl #(
  parameter int unsigned MAX_LEN       = 1024,
  parameter int unsigned ENG_LAT       = 1,
  parameter bit          CRC_LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        eng_init,
  output logic        eng_en,
  output logic [7:0]  eng_data,
  input  logic [31:0] eng_crc,
  output logic [15:0] frame_len,
  output logic        len_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    DATA,
    WAIT,
    APPEND
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [15:0] len_cnt;
  logic [15:0] len_inc;
  logic        at_max;
  logic [3:0]  wait_cnt;
  logic        wait_done;
  logic [31:0] crc_q;
  logic [1:0]  byte_idx;
  logic [1:0]  idx_sel;
  logic [7:0]  crc_byte;
  logic        accept;
  logic        frame_end;
  logic        trunc;
  logic        crc_take;
  logic        byte_adv;

  assign len_inc   = len_cnt + 16'd1;
  assign at_max    = (len_inc == 16'(MAX_LEN));
  assign wait_done = (wait_cnt == 4'(ENG_LAT - 1));

  // MSB-first order walks the bytes 3..0, i.e. the bitwise inverse of the index.
  assign idx_sel  = CRC_LSB_FIRST ? byte_idx : ~byte_idx;
  assign crc_byte = crc_q[{idx_sel, 3'b000} +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    m_data    = '0;
    eng_init  = 1'b0;
    eng_en    = 1'b0;
    eng_data  = '0;
    accept    = 1'b0;
    frame_end = 1'b0;
    trunc     = 1'b0;
    crc_take  = 1'b0;
    byte_adv  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (s_valid) state_d = INIT;
      end
      INIT: begin
        eng_init = 1'b1;
        state_d  = DATA;
      end
      DATA: begin
        m_data   = s_data;
        m_valid  = s_valid;
        s_ready  = m_ready;
        eng_en   = s_valid && m_ready;
        eng_data = s_data;
        accept   = s_valid && m_ready;
        // Reaching MAX_LEN without s_last closes the frame here; the rest of
        // the upstream stream starts a new frame.
        if (accept && (s_last || at_max)) begin
          frame_end = 1'b1;
          trunc     = !s_last;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (wait_done) begin
          crc_take = 1'b1;
          state_d  = APPEND;
        end
      end
      APPEND: begin
        m_valid  = 1'b1;
        m_data   = crc_byte;
        m_last   = (byte_idx == 2'd3);
        byte_adv = m_ready;
        if (m_ready && (byte_idx == 2'd3)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_cnt   <= '0;
      frame_len <= '0;
      len_err   <= 1'b0;
      wait_cnt  <= '0;
      crc_q     <= '0;
      byte_idx  <= '0;
    end else begin
      if (state == INIT) begin
        len_cnt <= '0;
        len_err <= 1'b0;
      end else if (accept) begin
        len_cnt <= len_inc;
      end

      if (frame_end) begin
        frame_len <= len_inc;
        if (trunc) len_err <= 1'b1;
      end

      if (state != WAIT) begin
        wait_cnt <= '0;
      end else if (!wait_done) begin
        wait_cnt <= wait_cnt + 4'd1;
      end

      if (crc_take) crc_q <= eng_crc;

      if (state != APPEND) begin
        byte_idx <= '0;
      end else if (byte_adv) begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_crc32_frame_ctrl.sv
// Directed bench: one controller with a reference CRC-32 engine, one with
// MAX_LEN=4, MSB-first order and a fixed engine result.
module tb_crc32_frame_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] s_data;
  logic       s_valid, s_last, m_ready, sel;

  logic        s_ready_a, m_valid_a, m_last_a, eng_init_a, eng_en_a, len_err_a, busy_a;
  logic [7:0]  m_data_a, eng_data_a;
  logic [15:0] frame_len_a;
  logic [31:0] eng_crc_a;

  logic        s_ready_b, m_valid_b, m_last_b, eng_init_b, eng_en_b, len_err_b, busy_b;
  logic [7:0]  m_data_b, eng_data_b;
  logic [15:0] frame_len_b;

  crc32_frame_ctrl u_a (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid && !sel), .s_last(s_last), .s_ready(s_ready_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_last(m_last_a), .m_ready(m_ready),
    .eng_init(eng_init_a), .eng_en(eng_en_a), .eng_data(eng_data_a), .eng_crc(eng_crc_a),
    .frame_len(frame_len_a), .len_err(len_err_a), .busy(busy_a)
  );

  crc32_frame_ctrl #(.MAX_LEN(4), .ENG_LAT(1), .CRC_LSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid && sel), .s_last(s_last), .s_ready(s_ready_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_last(m_last_b), .m_ready(m_ready),
    .eng_init(eng_init_b), .eng_en(eng_en_b), .eng_data(eng_data_b), .eng_crc(32'hDEADBEEF),
    .frame_len(frame_len_b), .len_err(len_err_b), .busy(busy_b)
  );

  // Reference engine: reflected CRC-32, init 0xFFFFFFFF, final inversion.
  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  logic [31:0] crc_st;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_st <= '1;
    else if (eng_init_a) crc_st <= '1;
    else if (eng_en_a) crc_st <= crc_upd(crc_st, eng_data_a);
  end
  assign eng_crc_a = ~crc_st;

  logic        s_ready_c, m_valid_c, m_last_c, eng_init_c, eng_en_c, len_err_c, busy_c;
  logic [7:0]  m_data_c;
  logic [15:0] frame_len_c;
  assign s_ready_c   = sel ? s_ready_b   : s_ready_a;
  assign m_valid_c   = sel ? m_valid_b   : m_valid_a;
  assign m_last_c    = sel ? m_last_b    : m_last_a;
  assign m_data_c    = sel ? m_data_b    : m_data_a;
  assign eng_init_c  = sel ? eng_init_b  : eng_init_a;
  assign eng_en_c    = sel ? eng_en_b    : eng_en_a;
  assign len_err_c   = sel ? len_err_b   : len_err_a;
  assign busy_c      = sel ? busy_b      : busy_a;
  assign frame_len_c = sel ? frame_len_b : frame_len_a;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Input bytes and expected output bytes are packed first-byte-in-MSB.
  typedef struct {
    string        name;
    logic         sel;
    logic         stall;
    int unsigned  n;
    logic [127:0] din;
    int unsigned  nfr;
    int unsigned  fl0, fl1;
    logic         err0, err1;
    logic [127:0] exp;
  } vec_t;

  vec_t vec[6];

  task automatic run_frame(input vec_t v, input int unsigned abort_at);
    int unsigned idx, outn, frames, cyc, n_init, n_en, viol, last_cyc, gap, idle_between, nexp;
    logic [7:0]  got[32];
    logic        gotl[32];
    logic [15:0] gl[2];
    logic        ge[2];
    logic        stalled, pv, pl;
    logic [7:0]  pd;
    idx = 0; outn = 0; frames = 0; cyc = 0; n_init = 0; n_en = 0; viol = 0;
    last_cyc = 0; gap = 0; idle_between = 0; stalled = 1'b0; pv = 1'b0; pl = 1'b0; pd = '0;
    sel = v.sel;
    while (frames < v.nfr && cyc < 500 && !(abort_at != 0 && outn >= abort_at)) begin
      @(negedge clk);
      cyc++;
      m_ready = v.stall ? cyc[0] : 1'b1;
      if (idx < v.n) begin
        s_valid = 1'b1;
        s_data  = v.din[8*(v.n-1-idx) +: 8];
        s_last  = (idx == v.n - 1);
      end else begin
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
      end
      #1;
      if (stalled && (m_valid_c !== pv || m_data_c !== pd || m_last_c !== pl)) viol++;
      if (s_ready_c && !m_ready) viol++;
      if (eng_en_c && eng_init_c) viol++;
      if (eng_en_c !== (s_valid && s_ready_c)) viol++;
      if (eng_init_c) n_init++;
      if (eng_en_c) n_en++;
      if (frames == 1 && gap == 0 && !busy_c) idle_between++;
      if (s_valid && s_ready_c) idx++;
      stalled = m_valid_c && !m_ready;
      pv = m_valid_c; pd = m_data_c; pl = m_last_c;
      if (m_valid_c && m_ready) begin
        if (outn < 32) begin
          got[outn]  = m_data_c;
          gotl[outn] = m_last_c;
        end
        if (frames == 1 && gap == 0) gap = cyc - last_cyc;
        outn++;
        if (m_last_c && frames < 2) begin
          gl[frames] = frame_len_c;
          ge[frames] = len_err_c;
          frames++;
          last_cyc = cyc;
        end
      end
    end
    if (abort_at != 0) begin
      chk({v.name, " outputs_before_reset"}, 64'(outn), 64'(abort_at));
      return;
    end
    nexp = v.fl0 + v.fl1 + 4 * v.nfr;
    chk({v.name, " frames"}, 64'(frames), 64'(v.nfr));
    chk({v.name, " out_count"}, 64'(outn), 64'(nexp));
    for (int unsigned i = 0; i < nexp && i < 32; i++) begin
      chk($sformatf("%s byte%0d", v.name, i), 64'(got[i]), 64'(v.exp[8*(nexp-1-i) +: 8]));
      chk($sformatf("%s last%0d", v.name, i), 64'(gotl[i]),
          64'((i == v.fl0 + 3) || (v.nfr == 2 && i == nexp - 1)));
    end
    chk({v.name, " frame_len0"}, 64'(gl[0]), 64'(v.fl0));
    chk({v.name, " len_err0"}, 64'(ge[0]), 64'(v.err0));
    if (v.nfr == 2) begin
      chk({v.name, " frame_len1"}, 64'(gl[1]), 64'(v.fl1));
      chk({v.name, " len_err1"}, 64'(ge[1]), 64'(v.err1));
      chk({v.name, " gap_cycles"}, 64'(gap), 64'd3);
      chk({v.name, " idle_cycles"}, 64'(idle_between), 64'd1);
    end
    chk({v.name, " eng_init_count"}, 64'(n_init), 64'(v.nfr));
    chk({v.name, " eng_en_count"}, 64'(n_en), 64'(v.n));
    chk({v.name, " protocol"}, 64'(viol), 64'd0);
  endtask

  function automatic logic [38:0] outs_a();
    return {s_ready_a, m_valid_a, m_last_a, m_data_a, eng_init_a, eng_en_a,
            eng_data_a, frame_len_a, len_err_a, busy_a};
  endfunction

  function automatic logic [38:0] outs_b();
    return {s_ready_b, m_valid_b, m_last_b, m_data_b, eng_init_b, eng_en_b,
            eng_data_b, frame_len_b, len_err_b, busy_b};
  endfunction

  initial begin
    int unsigned quiet;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1; sel = 1'b0;

    vec[0] = '{name:"std9", sel:1'b0, stall:1'b0, n:9, din:128'h313233343536373839,
               nfr:1, fl0:9, fl1:0, err0:1'b0, err1:1'b0,
               exp:128'h3132333435363738392639F4CB};
    vec[1] = '{name:"one", sel:1'b0, stall:1'b0, n:1, din:128'h31,
               nfr:1, fl0:1, fl1:0, err0:1'b0, err1:1'b0, exp:128'h31B7EFDC83};
    vec[2] = '{name:"std9_stall", sel:1'b0, stall:1'b1, n:9, din:128'h313233343536373839,
               nfr:1, fl0:9, fl1:0, err0:1'b0, err1:1'b0,
               exp:128'h3132333435363738392639F4CB};
    vec[3] = '{name:"abc_stall", sel:1'b0, stall:1'b1, n:3, din:128'h616263,
               nfr:1, fl0:3, fl1:0, err0:1'b0, err1:1'b0, exp:128'h616263C2412435};
    vec[4] = '{name:"trunc", sel:1'b1, stall:1'b0, n:6, din:128'h010203040506,
               nfr:2, fl0:4, fl1:2, err0:1'b1, err1:1'b0,
               exp:128'h01020304DEADBEEF0506DEADBEEF};
    vec[5] = '{name:"exact_max", sel:1'b1, stall:1'b1, n:4, din:128'hA0A1A2A3,
               nfr:1, fl0:4, fl1:0, err0:1'b0, err1:1'b0, exp:128'hA0A1A2A3DEADBEEF};

    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs_a", 64'(outs_a()), 64'd0);
    chk("reset_outputs_b", 64'(outs_b()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_frame(vec[i], 0);

    // Reset during APPEND, after the 2nd CRC byte has been consumed.
    run_frame(vec[0], 11);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    rst = 1'b1;
    #1;
    chk("midappend_reset_outputs", 64'(outs_a()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (m_valid_a || busy_a) quiet++;
    end
    chk("post_reset_quiet", 64'(quiet), 64'd0);
    vec[0].name = "after_reset";
    run_frame(vec[0], 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
